// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one asynchronous memory read port among PE_NUMBER
// requesters; the returned word is captured into a registered, ID-tagged response.
module mem_read_arbiter #(
    parameter int ADDR_SIZE = 10,
    parameter int WORD_SIZE = 16,
    parameter int PE_NUMBER = 64,
    parameter int ID_W      = $clog2(PE_NUMBER)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           arb_en,
    input  logic [PE_NUMBER-1:0]           req,
    input  logic [PE_NUMBER*ADDR_SIZE-1:0] req_addr,
    output logic [PE_NUMBER-1:0]           gnt,
    output logic [ADDR_SIZE-1:0]           mem_r_addr,
    input  logic [WORD_SIZE-1:0]           mem_r_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [WORD_SIZE-1:0]           rsp_data,
    output logic [31:0]                    grant_cnt
);

    localparam logic [ID_W:0]   PE_NUM_W = (ID_W+1)'(PE_NUMBER);
    localparam logic [ID_W-1:0] LAST_PE  = ID_W'(PE_NUMBER - 1);

    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      winner;
    logic                 any_req;
    logic                 can_issue;
    logic [ADDR_SIZE-1:0] addr_arr [PE_NUMBER];

    genvar g;
    generate
        for (g = 0; g < PE_NUMBER; g++) begin : g_addr
            assign addr_arr[g] = req_addr[g*ADDR_SIZE +: ADDR_SIZE];
        end
    endgenerate

    assign any_req   = |req;
    assign can_issue = arb_en && !rst && any_req && (!rsp_valid || rsp_ready);

    // Scan from ptr upward with an explicit modulo-PE_NUMBER wrap, so
    // non-power-of-2 requester counts behave correctly.
    always_comb begin : sel
        logic [ID_W:0] idx;
        logic          found;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < PE_NUMBER; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= PE_NUM_W) idx = idx - PE_NUM_W;
            if (!found && req[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        gnt        = '0;
        mem_r_addr = '0;
        if (can_issue) begin
            gnt[winner] = 1'b1;
            mem_r_addr  = addr_arr[winner];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            grant_cnt <= '0;
        end else if (can_issue) begin
            ptr       <= (winner == LAST_PE) ? '0 : winner + 1'b1;
            rsp_valid <= 1'b1;
            rsp_id    <= winner;
            rsp_data  <= mem_r_data;
            if (grant_cnt != 32'hFFFF_FFFF) grant_cnt <= grant_cnt + 32'd1;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed self-checking bench for mem_read_arbiter with a small memory model.
module tb_mem_read_arbiter;

    localparam int AW = 10;
    localparam int WW = 16;
    localparam int PN = 64;
    localparam int IW = 6;

    logic           clk = 0;
    logic           rst;
    logic           arb_en;
    logic [PN-1:0]  req;
    logic [PN*AW-1:0] req_addr;
    logic [PN-1:0]  gnt;
    logic [AW-1:0]  mem_r_addr;
    logic [WW-1:0]  mem_r_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [WW-1:0]  rsp_data;
    logic [31:0]    grant_cnt;

    logic [WW-1:0]  mem [1024];
    logic           host_we;
    logic [AW-1:0]  host_waddr;
    logic [WW-1:0]  host_wdata;

    int tests_run = 0;
    int tests_failed = 0;
    logic [PN-1:0] one = 64'd1;

    always #5 clk = ~clk;

    assign mem_r_data = mem[mem_r_addr];
    always @(posedge clk) if (host_we) mem[host_waddr] <= host_wdata;

    mem_read_arbiter #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .PE_NUMBER(PN)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .req(req), .req_addr(req_addr),
        .gnt(gnt), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .grant_cnt(grant_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; arb_en = 1; req = '0; req_addr = '0; rsp_ready = 1; host_we = 0;
        host_waddr = '0; host_wdata = '0;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got %0d want 0", rsp_valid); end
        tests_run++; if (gnt !== '0) begin tests_failed++; $display("FAIL reset_gnt got %h want 0", gnt); end
        tests_run++; if (grant_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_grant_cnt got %0d want 0", grant_cnt); end
        tests_run++; if (mem_r_addr !== '0) begin tests_failed++; $display("FAIL reset_mem_r_addr got %0d want 0", mem_r_addr); end
        tick();
    endtask

    task automatic test_single();
        req[5] = 1; req_addr[5*AW +: AW] = 10'd3;
        @(negedge clk);
        tests_run++; if (gnt !== (one << 5)) begin tests_failed++; $display("FAIL single_gnt got %h want %h", gnt, one << 5); end
        tests_run++; if (mem_r_addr !== 10'd3) begin tests_failed++; $display("FAIL single_addr got %0d want 3", mem_r_addr); end
        tick();
        req[5] = 0;
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid got %0d want 1", rsp_valid); end
        tests_run++; if (rsp_id !== 6'd5) begin tests_failed++; $display("FAIL single_id got %0d want 5", rsp_id); end
        tests_run++; if (rsp_data !== 16'h0103) begin tests_failed++; $display("FAIL single_data got %h want 0103", rsp_data); end
        tests_run++; if (gnt !== '0) begin tests_failed++; $display("FAIL single_gnt_idle got %h want 0", gnt); end
        tick();
    endtask

    // ptr is 6 here, so the scan reaches 63 first, then wraps to 0 and 1.
    task automatic test_round_robin();
        int exp_id [6] = '{63, 0, 1, 63, 0, 1};
        req[0] = 1; req[1] = 1; req[63] = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (gnt !== (one << exp_id[i])) begin
                tests_failed++; $display("FAIL rr_gnt[%0d] got %h want %h", i, gnt, one << exp_id[i]);
            end
            tick();
        end
        req = '0;
        @(negedge clk);
        tests_run++; if (rsp_id !== 6'd1) begin tests_failed++; $display("FAIL rr_last_id got %0d want 1", rsp_id); end
        tests_run++; if (grant_cnt !== 32'd7) begin tests_failed++; $display("FAIL rr_grant_cnt got %0d want 7", grant_cnt); end
        tick();
    endtask

    task automatic test_backpressure();
        req[2] = 1; req_addr[2*AW +: AW] = 10'd20;
        req[7] = 1; req_addr[7*AW +: AW] = 10'd21;
        rsp_ready = 0;
        @(negedge clk);
        tests_run++; if (gnt !== (one << 2)) begin tests_failed++; $display("FAIL bp_first_gnt got %h want %h", gnt, one << 2); end
        tick();
        req[2] = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (gnt !== '0 || rsp_valid !== 1'b1 || rsp_id !== 6'd2 || rsp_data !== 16'h0114) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d] got gnt=%h v=%0d id=%0d d=%h want gnt=0 v=1 id=2 d=0114",
                         i, gnt, rsp_valid, rsp_id, rsp_data);
            end
            tick();
        end
        rsp_ready = 1;
        @(negedge clk);
        tests_run++; if (gnt !== (one << 7)) begin tests_failed++; $display("FAIL bp_release_gnt got %h want %h", gnt, one << 7); end
        tick();
        req[7] = 0;
        @(negedge clk);
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 6'd7 || rsp_data !== 16'h0115) begin
            tests_failed++; $display("FAIL bp_second_rsp got v=%0d id=%0d d=%h want v=1 id=7 d=0115", rsp_valid, rsp_id, rsp_data);
        end
        tests_run++; if (grant_cnt !== 32'd9) begin tests_failed++; $display("FAIL bp_grant_cnt got %0d want 9", grant_cnt); end
        tick();
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained got %0d want 0", rsp_valid); end
        tick();
    endtask

    task automatic test_collision();
        req[4] = 1; req_addr[4*AW +: AW] = 10'd9;
        host_we = 1; host_waddr = 10'd9; host_wdata = 16'hBEEF;
        @(negedge clk);
        tests_run++; if (gnt !== (one << 4)) begin tests_failed++; $display("FAIL coll_gnt got %h want %h", gnt, one << 4); end
        tick();
        host_we = 0;
        @(negedge clk);
        tests_run++; if (rsp_data !== 16'h0109) begin tests_failed++; $display("FAIL coll_old_data got %h want 0109", rsp_data); end
        tests_run++; if (gnt !== (one << 4)) begin tests_failed++; $display("FAIL coll_repeat_gnt got %h want %h", gnt, one << 4); end
        tick();
        req[4] = 0;
        @(negedge clk);
        tests_run++; if (rsp_data !== 16'hBEEF) begin tests_failed++; $display("FAIL coll_new_data got %h want beef", rsp_data); end
        tests_run++; if (grant_cnt !== 32'd11) begin tests_failed++; $display("FAIL coll_grant_cnt got %0d want 11", grant_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        req[2] = 1; req_addr[2*AW +: AW] = 10'd30;
        tick();                      // PE 2 granted, ptr becomes 3
        req = '0; req[1] = 1; req[2] = 1; req[10] = 1;
        rst = 1;
        @(negedge clk);
        tests_run++; if (gnt !== '0) begin tests_failed++; $display("FAIL rstmid_gnt_forced got %h want 0", gnt); end
        tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pending got %0d want 1", rsp_valid); end
        tick();
        rst = 0; arb_en = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || grant_cnt !== '0 || gnt !== '0) begin
                tests_failed++;
                $display("FAIL rstmid_state[%0d] got v=%0d id=%0d d=%h cnt=%0d gnt=%h want all 0",
                         i, rsp_valid, rsp_id, rsp_data, grant_cnt, gnt);
            end
            tick();
        end
        arb_en = 1;
        @(negedge clk);
        // ptr back at 0 picks PE 1; a stale ptr of 3 would pick PE 10.
        tests_run++; if (gnt !== (one << 1)) begin tests_failed++; $display("FAIL rstmid_ptr_gnt got %h want %h", gnt, one << 1); end
        tick();
        arb_en = 0;
        @(negedge clk);
        tests_run++;
        if (gnt !== '0 || rsp_valid !== 1'b1 || rsp_id !== 6'd1) begin
            tests_failed++; $display("FAIL disabled_drain got gnt=%h v=%0d id=%0d want gnt=0 v=1 id=1", gnt, rsp_valid, rsp_id);
        end
        tick();
        @(negedge clk);
        tests_run++; if (rsp_valid !== 1'b0 || gnt !== '0) begin tests_failed++; $display("FAIL disabled_idle got v=%0d gnt=%h want 0 0", rsp_valid, gnt); end
        tests_run++; if (grant_cnt !== 32'd1) begin tests_failed++; $display("FAIL disabled_cnt got %0d want 1", grant_cnt); end
        req = '0;
        tick();
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 16'(k) + 16'h0100;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
